eth_frame_tx_gen: RTL and testbench
===================================

// Module: eth_frame_tx_gen
// PURPOSE
//  Consumer stage directly downstream of the payload-length calculator.
//  Drives its load/consume strobes (payload_en, payload_cal) and reads payload_len/remain_zero.
//  Splits a requested byte total into Ethernet frames: DA + SA + 16-bit length + incrementing payload.
//  Streams the frames as bytes on AXI4-Stream toward the tri-mode MAC TX client interface.
// PARAMETERS
//  LEN_W        16     width of length fields (matches calculator 2x8-bit bus)
//  IFG_CYCLES   12     idle clock cycles between consecutive frames (0 allowed)
//  PATTERN_SEED 8'h00  first payload byte of every frame
// PORTS
//  clk           in   1      system clock, all logic rising-edge
//  rst_n         in   1      async active-low reset
//  start         in   1      1-cycle request; honoured only in IDLE
//  dest_mac      in   48     DA, sampled at start, sent MSB byte first
//  src_mac       in   48     SA, sampled at start, sent MSB byte first
//  payload_len   in   LEN_W  length of next frame, from calculator
//  remain_zero   in   1      calculator remaining count == 0
//  payload_en    out  1      1-cycle pulse: calculator loads number_of_bytes
//  payload_cal   out  1      1-cycle pulse: calculator subtracts payload_len
//  m_axis_tdata  out  8      stream byte
//  m_axis_tvalid out  1      byte valid
//  m_axis_tlast  out  1      last byte of frame
//  m_axis_tready in   1      MAC accepts byte
//  busy          out  1      high outside IDLE
//  done          out  1      1-cycle pulse when whole request is sent
//  frame_cnt     out  LEN_W  frames sent since reset, wraps at 2^LEN_W
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream): all outputs 0, state IDLE, frame_cnt 0.
//  FSM:
//   IDLE -start-> LOAD
//   LOAD: payload_en=1 for one cycle -> SETTLE
//   SETTLE: one cycle for calculator register update.
//    remain_zero -> FIN; else latch payload_len into flen -> HDR
//   HDR: 14 bytes: DA[47:40]..DA[7:0], SA[47:40]..SA[7:0], flen[15:8], flen[7:0] -> PAY
//   PAY: flen bytes, value PATTERN_SEED+i mod 256; tlast on last byte (or in PAD if padding)
//   On the tlast handshake: payload_cal=1 in that same cycle -> GAP
//   GAP: IFG_CYCLES idle cycles, then one settle cycle.
//    remain_zero -> FIN; else latch payload_len -> HDR
//   FIN: done=1 for one cycle -> IDLE
//  AXI rules:
//   tvalid never drops, and tdata/tlast are held stable, until tready.
//   The byte index advances only on tvalid&&tready; no combinational tready->tvalid path.
//   Full throughput: one byte per cycle under continuous tready.
//  Arithmetic: byte counter LEN_W bits. Payload pattern wraps 8'hFF->8'h00. Length field carries unpadded flen.
//  payload_cal is never asserted together with payload_en; it fires exactly once per frame.
//  start while busy: ignored. start in the same cycle as the FIN->IDLE transition: ignored.
//  flen is 1..1500 by construction. A latched flen==0 with remain_zero==0 is an error: go to FIN.
//  Reset mid-frame: output drops immediately with no tlast. Calculator state is reloaded on the next start.
// CONFIGURATION
//  Macro ETH_FRAME_TX_MIN_PAD_EN:
//   Defined: if flen<46, PAD state appends (46-flen) bytes of 8'h00 after payload; tlast on last pad byte.
//   Not defined: no PAD state; frames may be shorter than 60 bytes (MAC pads).
// STRUCTURE
//  Package patgen_pkg holds:
//   - typedef enum tx_state_e {IDLE,LOAD,SETTLE,HDR,PAY,PAD,GAP,FIN}
//   - ETH_HDR_BYTES=14, ETH_MIN_PAYLOAD=46, ETH_MAX_PAYLOAD=1500
//   - typedef logic [LEN_W-1:0] len_t
//  Sub-module eth_hdr_byte_sel: combinational, hdr index 0..13 + DA/SA/flen -> header byte.
//  FSM, counters and AXI output register stay in the top.
// TESTING
//  1 total=100, tready=1 -> one frame of 114 bytes.
//    Bytes 12,13 = 8'h00,8'h64; payload 00..63; one payload_cal; done; frame_cnt=1.
//  2 total=3000 -> two frames, flen 1500 each; done after second tlast; frame_cnt=2.
//  3 total=2000 -> two frames of 1000 (calculator halving band); exactly 12-cycle idle gap between them.
//  4 total=20 with macro -> 60 bytes, last 26 are 00, length field 0x0014.
//    Without macro -> 34 bytes.
//  5 random tready (50%) during total=300 -> tdata/tvalid/tlast stable while stalled; byte sequence identical to case 1 style.
//  6 total=0 -> payload_en, then done 2 cycles later, no tvalid.
//    rst_n low mid-PAY -> all outputs 0 same cycle; next start sends correctly.

Source files
------------

// File: rtl/patgen_pkg.sv
// Shared types and Ethernet framing constants for the frame generator.
package patgen_pkg;

  localparam int LEN_W           = 16;
  localparam int ETH_HDR_BYTES   = 14;
  localparam int ETH_MIN_PAYLOAD = 46;
  localparam int ETH_MAX_PAYLOAD = 1500;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    HDR,
    PAY,
    PAD,
    GAP,
    FIN
  } tx_state_e;

endpackage

// File: rtl/eth_hdr_byte_sel.sv
// Combinational header byte mux: index 0..13 selects DA, SA (MSB byte first) then the length field.
module eth_hdr_byte_sel
  import patgen_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  len_t        flen,
  output logic [7:0]  hdr_byte
);

  always_comb begin
    hdr_byte = 8'h00;
    case (idx)
      4'd0:  hdr_byte = dest_mac[47:40];
      4'd1:  hdr_byte = dest_mac[39:32];
      4'd2:  hdr_byte = dest_mac[31:24];
      4'd3:  hdr_byte = dest_mac[23:16];
      4'd4:  hdr_byte = dest_mac[15:8];
      4'd5:  hdr_byte = dest_mac[7:0];
      4'd6:  hdr_byte = src_mac[47:40];
      4'd7:  hdr_byte = src_mac[39:32];
      4'd8:  hdr_byte = src_mac[31:24];
      4'd9:  hdr_byte = src_mac[23:16];
      4'd10: hdr_byte = src_mac[15:8];
      4'd11: hdr_byte = src_mac[7:0];
      4'd12: hdr_byte = flen[15:8];
      4'd13: hdr_byte = flen[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/eth_frame_tx_gen.sv
// Splits a byte total into Ethernet frames and streams them on AXI4-Stream.
// Optional minimum-payload padding is enabled by defining ETH_FRAME_TX_MIN_PAD_EN.
module eth_frame_tx_gen #(
  parameter int         LEN_W        = 16,
  parameter int         IFG_CYCLES   = 12,
  parameter logic [7:0] PATTERN_SEED = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [47:0]      dest_mac,
  input  logic [47:0]      src_mac,
  input  logic [LEN_W-1:0] payload_len,
  input  logic             remain_zero,
  output logic             payload_en,
  output logic             payload_cal,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] frame_cnt
);
  import patgen_pkg::*;

  tx_state_e        state, state_n;
  logic [LEN_W-1:0] idx, idx_n, flen;
  logic [47:0]      da, sa;
  logic [7:0]       hdr_byte, data_n;
  logic             last_n, valid_n, hs, pad_need, len_ok, next_frame_ok;

  assign hs            = m_axis_tvalid && m_axis_tready;
  assign len_ok        = (payload_len != '0) && (payload_len <= LEN_W'(ETH_MAX_PAYLOAD));
  assign next_frame_ok = !remain_zero && len_ok;

`ifdef ETH_FRAME_TX_MIN_PAD_EN
  assign pad_need = (flen < LEN_W'(ETH_MIN_PAYLOAD));
`else
  assign pad_need = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    state_n = SETTLE;
      SETTLE:  state_n = next_frame_ok ? HDR : FIN;
      HDR:     if (hs && idx == LEN_W'(ETH_HDR_BYTES - 1)) state_n = PAY;
      PAY:     if (hs && idx == flen - LEN_W'(1)) state_n = pad_need ? PAD : GAP;
      PAD:     if (hs && idx == LEN_W'(ETH_MIN_PAYLOAD - 1)) state_n = GAP;
      // The last GAP count doubles as the settle cycle for the calculator.
      GAP:     if (idx == LEN_W'(IFG_CYCLES)) state_n = next_frame_ok ? HDR : FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    payload_en  = (state == LOAD);
    payload_cal = hs && m_axis_tlast;
    done        = (state == FIN);
    busy        = (state != IDLE);
  end

  // Padding continues the payload index so its last byte is always index 45.
  always_comb begin
    idx_n = idx;
    if (state_n != state)              idx_n = (state_n == PAD) ? flen : '0;
    else if (hs || state == GAP)       idx_n = idx + LEN_W'(1);
  end

  eth_hdr_byte_sel u_hdr_sel (
    .idx      (idx_n[3:0]),
    .dest_mac (da),
    .src_mac  (sa),
    .flen     (len_t'(flen)),
    .hdr_byte (hdr_byte)
  );

  // Output register is loaded with the byte for the next (state, index); it holds while stalled.
  always_comb begin
    data_n  = 8'h00;
    last_n  = 1'b0;
    valid_n = 1'b0;
    case (state_n)
      HDR: begin
        valid_n = 1'b1;
        data_n  = hdr_byte;
      end
      PAY: begin
        valid_n = 1'b1;
        data_n  = PATTERN_SEED + idx_n[7:0];
        last_n  = (idx_n == flen - LEN_W'(1)) && !pad_need;
      end
      PAD: begin
        valid_n = 1'b1;
        last_n  = (idx_n == LEN_W'(ETH_MIN_PAYLOAD - 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      flen          <= '0;
      da            <= '0;
      sa            <= '0;
      frame_cnt     <= '0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      idx <= idx_n;
      if (state == IDLE && start) begin
        da <= dest_mac;
        sa <= src_mac;
      end
      if (state_n == HDR && state != HDR) flen <= payload_len;
      if (hs && m_axis_tlast) frame_cnt <= frame_cnt + LEN_W'(1);
      m_axis_tdata  <= data_n;
      m_axis_tvalid <= valid_n;
      m_axis_tlast  <= last_n;
    end
  end

endmodule

// File: tb/tb_eth_frame_tx_gen.sv
// Bench for eth_frame_tx_gen: payload-length calculator model, frame-level reference stream, AXI monitor.
`timescale 1ns/1ps
module tb_eth_frame_tx_gen;
  localparam int         LEN_W = 16;
  localparam int         IFG   = 12;
  localparam logic [7:0] SEED  = 8'h00;
`ifdef ETH_FRAME_TX_MIN_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif
  localparam int BUDGET = 16000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [47:0]      dest_mac = '0;
  logic [47:0]      src_mac = '0;
  logic [LEN_W-1:0] payload_len;
  logic             remain_zero;
  logic             payload_en, payload_cal;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tvalid, m_axis_tlast;
  logic             m_axis_tready = 1'b0;
  logic             busy, done;
  logic [LEN_W-1:0] frame_cnt;

  eth_frame_tx_gen #(.LEN_W(LEN_W), .IFG_CYCLES(IFG), .PATTERN_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dest_mac(dest_mac), .src_mac(src_mac),
    .payload_len(payload_len), .remain_zero(remain_zero), .payload_en(payload_en),
    .payload_cal(payload_cal), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .busy(busy), .done(done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Upstream calculator: full frames up to 1500, halves totals in (1500,3000].
  int remain = 0;
  int total_req = 0;

  function automatic int calc_len(input int r);
    if (r <= 1500) return r;
    if (r <= 3000) return (r + 1) / 2;
    return 1500;
  endfunction

  always @(posedge clk) begin
    if (payload_en)       remain <= total_req;
    else if (payload_cal) remain <= remain - calc_len(remain);
  end
  assign payload_len = LEN_W'(calc_len(remain));
  assign remain_zero = (remain == 0);

  // Reference stream: 9-bit entries {tlast, byte}.
  logic [8:0] exp_q[$];
  int exp_nframes;

  function automatic void build_expected(input int total, input logic [47:0] da, input logic [47:0] sa);
    int r, l, pad, n;
    logic [7:0] b;
    exp_q.delete();
    exp_nframes = 0;
    r = total;
    while (r > 0) begin
      l = calc_len(r);
      pad = (PAD_ON && l < 46) ? 46 - l : 0;
      n = 14 + l + pad;
      for (int k = 0; k < n; k++) begin
        if (k < 6)           b = 8'(da >> (8 * (5 - k)));
        else if (k < 12)     b = 8'(sa >> (8 * (11 - k)));
        else if (k == 12)    b = 8'(l >> 8);
        else if (k == 13)    b = 8'(l);
        else if (k < 14 + l) b = 8'((int'(SEED) + k - 14) % 256);
        else                 b = 8'h00;
        exp_q.push_back({(k == n - 1), b});
      end
      exp_nframes++;
      r -= l;
    end
  endfunction

  int ready_pct = 100;
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = (int'($urandom_range(99)) < ready_pct);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] cap_q[$];
  int gap_q[$];
  int en_cyc, done_cyc, done_cnt, cal_cnt, gap_len;
  bit in_gap = 1'b0;
  bit stall_prev = 1'b0;
  logic [8:0] stall_val;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      in_gap = 1'b0;
    end else begin
      if (stall_prev)
        check("axi_hold_while_stalled", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, stall_val});
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_val  = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) cap_q.push_back({m_axis_tlast, m_axis_tdata});
      if (payload_en)  en_cyc = cyc;
      if (payload_cal) cal_cnt++;
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        in_gap = 1'b1;
        gap_len = 0;
      end else if (in_gap) begin
        if (m_axis_tvalid) begin
          gap_q.push_back(gap_len);
          in_gap = 1'b0;
        end else begin
          gap_len++;
        end
      end
      if (done) in_gap = 1'b0;
    end
  end

  function automatic int cap_byte(input int i);
    if (i < cap_q.size()) return int'(cap_q[i][7:0]);
    return -1;
  endfunction

  int exp_fc = 0;

  task automatic clear_monitor();
    cap_q.delete();
    gap_q.delete();
    done_cnt = 0;
    cal_cnt = 0;
    en_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic launch(input int total, input int pct, output logic [47:0] da, output logic [47:0] sa);
    da = {16'($urandom), $urandom};
    sa = {16'($urandom), $urandom};
    ready_pct = pct;
    build_expected(total, da, sa);
    clear_monitor();
    @(posedge clk);
    #1;
    dest_mac = da;
    src_mac = sa;
    total_req = total;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dest_mac = '0;
    src_mac = '0;
  endtask

  task automatic run_request(input int total, input int pct, input string tag);
    logic [47:0] da, sa;
    int budget, bad;
    launch(total, pct, da, sa);
    budget = 0;
    while (done_cnt == 0 && budget < BUDGET) begin
      @(posedge clk);
      budget++;
    end
    check({tag, " done_seen"}, (done_cnt > 0), 1);
    repeat (3) @(posedge clk);
    #1;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= cap_q.size() || cap_q[i] !== exp_q[i])) bad = i;
    check({tag, " byte_count"}, cap_q.size(), exp_q.size());
    check({tag, " first_bad_byte_index"}, bad, -1);
    check({tag, " payload_cal_pulses"}, cal_cnt, exp_nframes);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " busy_after_done"}, busy, 0);
    exp_fc += exp_nframes;
    check({tag, " frame_cnt"}, frame_cnt, exp_fc % 65536);
  endtask

  typedef struct {
    int total;
    int pct;
    int exp_bytes;
    int exp_frames;
    int len_hi;
    int len_lo;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [47:0] da, sa;
    int budget;

    vecs[0] = '{100,  100, 114,               1, 8'h00, 8'h64};
    vecs[1] = '{3000, 100, 3028,              2, 8'h05, 8'hDC};
    vecs[2] = '{2000, 100, 2028,              2, 8'h03, 8'hE8};
    vecs[3] = '{20,   100, PAD_ON ? 60 : 34,  1, 8'h00, 8'h14};
    vecs[4] = '{300,  50,  314,               1, 8'h01, 8'h2C};
    vecs[5] = '{46,   100, 60,                1, 8'h00, 8'h2E};
    vecs[6] = '{45,   100, PAD_ON ? 60 : 59,  1, 8'h00, 8'h2D};
    vecs[7] = '{1,    100, PAD_ON ? 60 : 15,  1, 8'h00, 8'h01};
    vecs[8] = '{4500, 100, 4542,              3, 8'h05, 8'hDC};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done, payload_en, payload_cal}, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d_total%0d", i, vecs[i].total);
      run_request(vecs[i].total, vecs[i].pct, tag);
      check({tag, " dut_bytes"}, cap_q.size(), vecs[i].exp_bytes);
      check({tag, " dut_frames"}, cal_cnt, vecs[i].exp_frames);
      check({tag, " len_field_hi"}, cap_byte(12), vecs[i].len_hi);
      check({tag, " len_field_lo"}, cap_byte(13), vecs[i].len_lo);
      check({tag, " gap_count"}, gap_q.size(), vecs[i].exp_frames - 1);
      foreach (gap_q[g]) check({tag, " idle_gap_plus_settle"}, gap_q[g], IFG + 1);
    end

    // Empty request: load, settle, done; nothing on the stream.
    launch(0, 100, da, sa);
    repeat (6) @(posedge clk);
    #1;
    check("zero_total bytes", cap_q.size(), 0);
    check("zero_total done_pulses", done_cnt, 1);
    check("zero_total done_after_load", done_cyc - en_cyc, 2);
    check("zero_total payload_cal", cal_cnt, 0);

    // Reset in the middle of the payload, then a clean request.
    launch(300, 100, da, sa);
    budget = 0;
    while (cap_q.size() < 30 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    check("mid_pay reached", (cap_q.size() >= 30), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_pay reset_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done, payload_en, payload_cal}, 0);
    check("mid_pay reset_frame_cnt", frame_cnt, 0);
    exp_fc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_request(300, 100, "after_reset");

    for (int r = 0; r < 5; r++) begin
      int tot, pct;
      tot = int'($urandom_range(2500));
      pct = int'($urandom_range(40, 100));
      run_request(tot, pct, $sformatf("rand%0d_total%0d_pct%0d", r, tot, pct));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
